hdmi_core: RTL and testbench

HDMI_CORE -- requirements
Module: hdmi_core

---
 rtl/hdmi_core_pkg.sv | 27 ++
 rtl/hdmi_core_if.sv | 31 +++
 rtl/hdmi_timing_gen.sv | 95 +++++++++
 rtl/hdmi_core.sv | 146 ++++++++++++++
 tb/tb_hdmi_core.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/hdmi_core_pkg.sv
// hdmi_core_pkg
// Shared definitions for the HDMI video core: 720p60 timing defaults,
// the counter type used for the raster position, the IDLE/RUN state
// enum and the RGB565 -> RGB888 zero-fill expansion.
package hdmi_core_pkg;

  localparam int HRES_720P   = 1280;
  localparam int H_FP_720P   = 110;
  localparam int H_SYNC_720P = 40;
  localparam int H_BP_720P   = 220;
  localparam int VRES_720P   = 720;
  localparam int V_FP_720P   = 5;
  localparam int V_SYNC_720P = 5;
  localparam int V_BP_720P   = 20;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {IDLE, RUN} state_t;

  // Low bits are zero-filled rather than replicated, so full-scale
  // 565 white becomes F8/FC/F8.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
    return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/hdmi_core_if.sv
// hdmi_core_if
// Bundles the video output, FIFO and DMA strobe signals of hdmi_core.
// master: the core (drives video and strobes, receives start/color).
// slave : the surrounding system (FIFO, DMA engine, HDMI PHY).
interface hdmi_core_if;
  logic        start;
  logic [31:0] color;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        ve;
  logic        read_fifo;
  logic        read_go;
  logic        read_next_line;
  logic        read_next_chunk;
  logic        read_done;

  modport master (
    input  start, color,
    output red, green, blue, hsync, vsync, ve,
           read_fifo, read_go, read_next_line, read_next_chunk, read_done
  );

  modport slave (
    output start, color,
    input  red, green, blue, hsync, vsync, ve,
           read_fifo, read_go, read_next_line, read_next_chunk, read_done
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen
// Raster counters and IDLE/RUN control for hdmi_core.
// Ports: clock, reset (async, active-high), start (level enable);
//        run (state is RUN), h/v (raster position), hsync/vsync/ve
//        (combinational timing terms), h_active/v_active (inside the
//        active area horizontally / vertically). All terms are 0 in IDLE.
module hdmi_timing_gen
  import hdmi_core_pkg::*;
#(
  parameter int HRES   = HRES_720P,
  parameter int H_FP   = H_FP_720P,
  parameter int H_SYNC = H_SYNC_720P,
  parameter int H_BP   = H_BP_720P,
  parameter int VRES   = VRES_720P,
  parameter int V_FP   = V_FP_720P,
  parameter int V_SYNC = V_SYNC_720P,
  parameter int V_BP   = V_BP_720P
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic run,
  output cnt_t h,
  output cnt_t v,
  output logic hsync,
  output logic vsync,
  output logic ve,
  output logic h_active,
  output logic v_active
);

  localparam int H_TOTAL = HRES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = VRES + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_ACT_END = cnt_t'(VRES - 1);

  state_t state_q, state_d;
  cnt_t   h_q, h_d;
  cnt_t   v_q, v_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Frames start at v=VRES so every frame opens with vertical blanking,
  // which gives the DMA time to prefetch. A frame therefore ends at the
  // last active line; that is the only point where RUN may drop to IDLE.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          h_d     = '0;
          v_d     = cnt_t'(VRES);
        end
      end
      RUN: begin
        if (h_q == H_LAST) begin
          if (v_q == V_ACT_END && !start) begin
            state_d = IDLE;
          end else begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
          end
        end else begin
          h_d = h_q + cnt_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run      = (state_q == RUN);
  assign h        = h_q;
  assign v        = v_q;
  assign h_active = run && (h_q < cnt_t'(HRES));
  assign v_active = run && (v_q < cnt_t'(VRES));
  assign ve       = h_active && v_active;
  assign hsync    = run && (h_q >= cnt_t'(HRES + H_FP)) && (h_q < cnt_t'(HRES + H_FP + H_SYNC));
  assign vsync    = run && (v_q >= cnt_t'(VRES + V_FP)) && (v_q < cnt_t'(VRES + V_FP + V_SYNC));

endmodule

// File: rtl/hdmi_core.sv
// hdmi_core
// Video output core: pixel unpacking from a first-word-fall-through FIFO,
// DMA request strobes and registered HDMI-style video timing.
// Ports: clock (pixel clock), reset (async, active-high),
//        vid (hdmi_core_if.master): start, color in; red/green/blue,
//        hsync/vsync/ve, read_fifo, read_go, read_next_line,
//        read_next_chunk, read_done out. Every output is registered once.
// Build option: HDMI_CORE_TEST_PATTERN_EN replaces FIFO pixel data with
// eight vertical colour bars; the read strobes are unaffected.
module hdmi_core
  import hdmi_core_pkg::*;
#(
  parameter int NUM_BYTES_PER_PIXEL = 2,
  parameter int HRES        = HRES_720P,
  parameter int H_FP        = H_FP_720P,
  parameter int H_SYNC      = H_SYNC_720P,
  parameter int H_BP        = H_BP_720P,
  parameter int VRES        = VRES_720P,
  parameter int V_FP        = V_FP_720P,
  parameter int V_SYNC      = V_SYNC_720P,
  parameter int V_BP        = V_BP_720P,
  parameter int CHUNK_WORDS = 32
) (
  input logic         clock,
  input logic         reset,
  hdmi_core_if.master vid
);

  localparam int PPW      = 4 / NUM_BYTES_PER_PIXEL;
  localparam int N_CHUNKS = HRES / (PPW * CHUNK_WORDS);
  localparam int V_TOTAL  = VRES + V_FP + V_SYNC + V_BP;

  logic run, hsync_c, vsync_c, ve_c, h_active, v_active;
  cnt_t h, v;

  hdmi_timing_gen #(
    .HRES(HRES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .VRES(VRES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock    (clock),
    .reset    (reset),
    .start    (vid.start),
    .run      (run),
    .h        (h),
    .v        (v),
    .hsync    (hsync_c),
    .vsync    (vsync_c),
    .ve       (ve_c),
    .h_active (h_active),
    .v_active (v_active)
  );

  // PPW is 1 or 2, so the pixel slot within a word is just the low h bits.
  cnt_t k;
  logic k_last;
  assign k      = h & cnt_t'(PPW - 1);
  assign k_last = (k == cnt_t'(PPW - 1));

  // The line being drawn has an active successor (including the last
  // blanking line, which precedes line 0): fetch the next line now.
  logic prefetch_line;
  assign prefetch_line = run && ((v == cnt_t'(V_TOTAL - 1)) || (v < cnt_t'(VRES - 1)));

  logic fifo_c, go_c, next_line_c, next_chunk_c, done_c;
  assign fifo_c       = h_active && v_active && k_last;
  assign go_c         = run && (h == '0) && (v == cnt_t'(VRES));
  assign next_line_c  = prefetch_line && (h == cnt_t'(HRES));
  assign next_chunk_c = prefetch_line && (h > cnt_t'(HRES)) && (h <= cnt_t'(HRES + N_CHUNKS));
  assign done_c       = run && (h == cnt_t'(HRES)) && (v == cnt_t'(VRES - 1));

  // Pixel colour before the output register; forced to black outside ve.
  logic [23:0] rgb_c;
`ifdef HDMI_CORE_TEST_PATTERN_EN
  cnt_t bar;
  assign bar = h / cnt_t'(HRES / 8);
  always_comb begin
    rgb_c = '0;
    if (ve_c) begin
      case (bar[2:0])
        3'd0:    rgb_c = 24'hFFFFFF;
        3'd1:    rgb_c = 24'hFFFF00;
        3'd2:    rgb_c = 24'h00FFFF;
        3'd3:    rgb_c = 24'h00FF00;
        3'd4:    rgb_c = 24'hFF00FF;
        3'd5:    rgb_c = 24'hFF0000;
        3'd6:    rgb_c = 24'h0000FF;
        default: rgb_c = 24'h000000;
      endcase
    end
  end
`else
  always_comb begin
    rgb_c = '0;
    if (ve_c) begin
      if (NUM_BYTES_PER_PIXEL == 4) begin
        rgb_c = vid.color[23:0];
      end else if (k == '0) begin
        rgb_c = rgb565_to_rgb888(vid.color[31:16]);
      end else begin
        rgb_c = rgb565_to_rgb888(vid.color[15:0]);
      end
    end
  end
`endif

  logic [23:0] rgb_q;
  logic hsync_q, vsync_q, ve_q, fifo_q, go_q, next_line_q, next_chunk_q, done_q;

  // Single output register stage keeps every output aligned and glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      ve_q         <= 1'b0;
      fifo_q       <= 1'b0;
      go_q         <= 1'b0;
      next_line_q  <= 1'b0;
      next_chunk_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rgb_q        <= rgb_c;
      hsync_q      <= hsync_c;
      vsync_q      <= vsync_c;
      ve_q         <= ve_c;
      fifo_q       <= fifo_c;
      go_q         <= go_c;
      next_line_q  <= next_line_c;
      next_chunk_q <= next_chunk_c;
      done_q       <= done_c;
    end
  end

  assign vid.red             = rgb_q[23:16];
  assign vid.green           = rgb_q[15:8];
  assign vid.blue            = rgb_q[7:0];
  assign vid.hsync           = hsync_q;
  assign vid.vsync           = vsync_q;
  assign vid.ve              = ve_q;
  assign vid.read_fifo       = fifo_q;
  assign vid.read_go         = go_q;
  assign vid.read_next_line  = next_line_q;
  assign vid.read_next_chunk = next_chunk_q;
  assign vid.read_done       = done_q;

endmodule

// File: tb/tb_hdmi_core.sv
// tb_hdmi_core
// Directed bench for hdmi_core on a shrunken raster so whole frames fit:
// HRES=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); VRES=4, V_FP=1,
// V_SYNC=1, V_BP=2 (V_TOTAL=8); RGB565, CHUNK_WORDS=4 -> 2 chunks/line.
module tb_hdmi_core;

  logic clock;
  logic reset;
  int   check_count;
  int   fail_count;

  hdmi_core_if vif();

  hdmi_core #(
    .NUM_BYTES_PER_PIXEL(2),
    .HRES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .VRES(4),  .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CHUNK_WORDS(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .vid   (vif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Per-frame statistics gathered while walking one frame of samples.
  int n_go, go_h, go_v, n_hs, hs_h, n_vs, vs_v, n_ve, n_fifo, fifo_h;
  int n_nl, n_nc, nc_h, nc_last_h, n_done, done_h, done_v, n_blank_rgb;
  logic [23:0] pix0, pix1, pix15;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic start_v, input logic [31:0] color_v);
    reset     = rst_v;
    vif.start = start_v;
    vif.color = color_v;
  endtask

  function automatic logic [63:0] out_vec();
    return {30'b0, vif.red, vif.green, vif.blue, vif.hsync, vif.vsync, vif.ve,
            vif.read_fifo, vif.read_go, vif.read_next_line, vif.read_next_chunk,
            vif.read_done};
  endfunction

  // Walks 192 samples; sample i shows the outputs for raster position
  // (oh, ov), starting at (0, VRES). start is dropped at sample drop_at.
  task automatic runFrame(input int drop_at);
    int oh, ov;
    oh = 0; ov = 4;
    n_go = 0; go_h = -1; go_v = -1; n_hs = 0; hs_h = -1; n_vs = 0; vs_v = -1;
    n_ve = 0; n_fifo = 0; fifo_h = -1; n_nl = 0; n_nc = 0; nc_h = -1; nc_last_h = -1;
    n_done = 0; done_h = -1; done_v = -1; n_blank_rgb = 0;
    pix0 = '0; pix1 = '0; pix15 = '0;
    for (int i = 0; i < 192; i++) begin
      @(negedge clock);
      if (i == drop_at) vif.start = 1'b0;
      if (vif.read_go) begin n_go++; go_h = oh; go_v = ov; end
      if (vif.hsync) begin n_hs++; if (hs_h < 0) hs_h = oh; end
      if (vif.vsync) begin n_vs++; if (vs_v < 0) vs_v = ov; end
      if (vif.ve) n_ve++;
      if (!vif.ve && {vif.red, vif.green, vif.blue} != 24'h0) n_blank_rgb++;
      if (vif.read_fifo) begin n_fifo++; if (fifo_h < 0) fifo_h = oh; end
      if (vif.read_next_line) n_nl++;
      if (vif.read_next_chunk) begin n_nc++; if (nc_h < 0) nc_h = oh; nc_last_h = oh; end
      if (vif.read_done) begin n_done++; done_h = oh; done_v = ov; end
      if (ov == 0 && oh == 0)  pix0  = {vif.red, vif.green, vif.blue};
      if (ov == 0 && oh == 1)  pix1  = {vif.red, vif.green, vif.blue};
      if (ov == 0 && oh == 15) pix15 = {vif.red, vif.green, vif.blue};
      oh++;
      if (oh == 24) begin
        oh = 0;
        ov = (ov == 7) ? 0 : ov + 1;
      end
    end
  endtask

  task automatic checkFrame();
    checkOutput("go_count",        n_go, 1);
    checkOutput("go_pos",          {go_h[31:0], go_v[31:0]}, {32'd0, 32'd4});
    checkOutput("hsync_count",     n_hs, 24);
    checkOutput("hsync_first_h",   hs_h, 18);
    checkOutput("vsync_count",     n_vs, 24);
    checkOutput("vsync_line",      vs_v, 5);
    checkOutput("ve_count",        n_ve, 64);
    checkOutput("blank_rgb_zero",  n_blank_rgb, 0);
    checkOutput("fifo_count",      n_fifo, 32);
    checkOutput("fifo_first_h",    fifo_h, 1);
    checkOutput("next_line_count", n_nl, 4);
    checkOutput("chunk_count",     n_nc, 8);
    checkOutput("chunk_first_h",   nc_h, 17);
    checkOutput("chunk_last_h",    nc_last_h, 18);
    checkOutput("done_count",      n_done, 1);
    checkOutput("done_pos",        {done_h[31:0], done_v[31:0]}, {32'd16, 32'd3});
    checkOutput("pixel_k0",        pix0,  24'hF02010);
    checkOutput("pixel_k1",        pix1,  24'hA070F0);
    checkOutput("pixel_last",      pix15, 24'hA070F0);
  endtask

  initial begin
    logic seen;
    check_count = 0;
    fail_count  = 0;
    applyStimulus(1'b1, 1'b0, 32'hF102A39E);
    repeat (2) @(negedge clock);

    // start raised while reset is still held: nothing may come out.
    applyStimulus(1'b1, 1'b1, 32'hF102A39E);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("reset_outputs", out_vec(), 64'h0);
    end

    applyStimulus(1'b0, 1'b1, 32'hF102A39E);
    @(negedge clock);
    checkOutput("go_before_run", vif.read_go, 1'b0);

    runFrame(-1);
    checkFrame();

    // Second frame: start drops early, the frame still completes.
    runFrame(50);
    checkFrame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("idle_after_drop", out_vec(), 64'h0);
    end

    // Restart from IDLE, then hit reset in the middle of an active line.
    applyStimulus(1'b0, 1'b1, 32'hF102A39E);
    @(negedge clock);
    checkOutput("restart_go_early", vif.read_go, 1'b0);
    @(negedge clock);
    checkOutput("restart_go", vif.read_go, 1'b1);

    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clock);
      if (vif.ve) seen = 1'b1;
    end
    checkOutput("ve_seen", seen, 1'b1);
    #2;
    applyStimulus(1'b1, 1'b1, 32'hF102A39E);
    #1;
    checkOutput("reset_async", out_vec(), 64'h0);
    @(negedge clock);
    checkOutput("reset_held", out_vec(), 64'h0);

    applyStimulus(1'b0, 1'b0, 32'hF102A39E);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("idle_after_reset", out_vec(), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
